arb_mux: RTL



---
 rtl/arb_mux.sv | 120 ++++++++++++
 1 files changed

// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - N-channel arbitrating mux with valid/ready handshakes and a registered output stage
// Grant comes from forced select, fixed priority or round-robin; the output register holds a beat until accepted.
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic                 force_en,
  input  logic [SELW-1:0]      force_sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load;
  logic             grant_any;
  logic [SELW-1:0]  grant_idx;
  logic [N-1:0]     grant;
  logic [WIDTH-1:0] grant_data;
  logic             transfer;

  assign load = !out_valid_q || out_ready;

  always_comb begin : arbitrate
    int best;
    int off;
    int base;
    grant_idx = '0;
    grant_any = 1'b0;
    best      = N;
    off       = 0;
    base      = int'(ptr_q);
    if (force_en) begin
      // An out-of-range force_sel simply matches no channel.
      for (int i = 0; i < N; i++) begin
        if (force_sel == SELW'(i) && in_valid[i]) begin
          grant_idx = SELW'(i);
          grant_any = 1'b1;
        end
      end
    end else if (mode) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant_idx = SELW'(i);
          grant_any = 1'b1;
        end
      end
    end else begin
      // Distance from ptr+1 going upward with wrap; smallest distance wins, so ptr itself is last.
      for (int i = 0; i < N; i++) begin
        off = (i + N - base - 1) % N;
        if (in_valid[i] && off < best) begin
          best      = off;
          grant_idx = SELW'(i);
          grant_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant      = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant[i]   = grant_any;
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = (rst_n && load) ? grant : '0;
  assign transfer = rst_n && load && grant_any;

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = transfer;
    end
    if (transfer) begin
      out_data_d = grant_data;
      out_sel_d  = grant_idx;
      ptr_d      = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      ptr_q       <= SELW'(N - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;

endmodule
